// File: rtl/instr_encoder_loader.sv
//======================================================================
// Module  : instr_encoder_loader
// Purpose : Packs RV32I instruction fields into 32-bit words and writes
//           them sequentially into instruction memory.
// Options : ENC_RANGE_CHECK_EN - reject immediates that do not fit
// Revision: 1.0 - initial release
//======================================================================
`default_nettype none

module instr_encoder_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic              in_last,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic              in_f7b5,
   input  logic [31:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] c_full = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] c_last = c_full - 1'b1;

   localparam logic [2:0] c_k_lw  = 3'd0;
   localparam logic [2:0] c_k_sw  = 3'd1;
   localparam logic [2:0] c_k_r   = 3'd2;
   localparam logic [2:0] c_k_i   = 3'd3;
   localparam logic [2:0] c_k_br  = 3'd4;
   localparam logic [2:0] c_k_jal = 3'd5;
   localparam logic [2:0] c_k_lui = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [ADDR_W:0]     r_count;
   logic                r_err;

   logic                w_ready;
   logic                w_accept;
   logic                w_reject;
   logic                w_write;
   logic [31:0]         w_enc;

   // The write pointer is the low bits of the word count; both clear together on start.
   assign w_ready  = (r_state == ST_LOAD) & ~start & (r_count < c_full);
   assign w_accept = in_valid & w_ready;
   assign w_write  = w_accept & ~w_reject;

   always_comb begin
      w_enc = 32'h0;
      case (in_kind)
         c_k_lw:  w_enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
         c_k_sw:  w_enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
         c_k_r:   w_enc = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
         c_k_i: begin
            // Shift-immediate forms carry funct7 above a 5-bit shamt.
            if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
               w_enc = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            else
               w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
         end
         c_k_br:  w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], 7'b1100011};
         c_k_jal: w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
         c_k_lui: w_enc = {in_imm[31:12], in_rd, 7'b0110111};
         default: w_enc = 32'h0;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   logic w_fit12;
   logic w_fit13;
   logic w_fit21;

   assign w_fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign w_fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
   assign w_fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

   always_comb begin
      w_reject = 1'b0;
      case (in_kind)
         c_k_lw, c_k_sw, c_k_i: w_reject = ~w_fit12;
         c_k_r:                 w_reject = 1'b0;
         c_k_br:                w_reject = in_imm[0] | ~w_fit13;
         c_k_jal:               w_reject = in_imm[0] | ~w_fit21;
         c_k_lui:               w_reject = |in_imm[11:0];
         default:               w_reject = 1'b1;
      endcase
   end
`else
   assign w_reject = (in_kind == 3'd7);
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (start)
               w_state_nxt = ST_LOAD;
            else if (w_accept && (in_last || (w_write && r_count == c_last)))
               w_state_nxt = ST_DONE;
         end
         ST_DONE: if (start) w_state_nxt = ST_LOAD;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= 32'h0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_we    <= w_write;
         r_err   <= w_accept & w_reject;
         if (w_write) begin
            r_addr  <= r_count[ADDR_W-1:0];
            r_wdata <= w_enc;
         end
         if (start)
            r_count <= '0;
         else if (w_write)
            r_count <= r_count + 1'b1;
      end
   end

   assign in_ready   = w_ready;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign count      = r_count;
   assign busy       = (r_state == ST_LOAD);
   assign done       = (r_state == ST_DONE);
   assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
//======================================================================
// Module  : tb_instr_encoder_loader
// Purpose : Directed and randomized checks of instr_encoder_loader
//           against a field-arithmetic reference model.
// Revision: 1.0 - initial release
//======================================================================
`default_nettype none

module tb_instr_encoder_loader;

   localparam int AW  = 4;
   localparam int CAP = 1 << AW;
`ifdef ENC_RANGE_CHECK_EN
   localparam bit c_check = 1'b1;
`else
   localparam bit c_check = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start, in_valid, in_ready, in_last, in_f7b5;
   logic [2:0]    in_kind, in_funct3;
   logic [4:0]    in_rd, in_rs1, in_rs2;
   logic [31:0]   in_imm;
   logic          imem_we, busy, done, err;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   count;

   instr_encoder_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_last(in_last), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .count(count), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;
   int m_count = 0;
   int m_state = 0;   // 0 idle, 1 loading, 2 finished

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_enc(input int k, input logic [31:0] d, input logic [31:0] r1,
                                         input logic [31:0] r2, input logic [31:0] f3,
                                         input logic [31:0] f7, input logic [31:0] im);
      logic [31:0] regs;
      regs = (r2 << 20) | (r1 << 15) | (f3 << 12) | (d << 7);
      case (k)
         0: return ((im & 32'hfff) << 20) | (r1 << 15) | (32'd2 << 12) | (d << 7) | 32'd3;
         1: return (((im >> 5) & 32'h7f) << 25) | (r2 << 20) | (r1 << 15) | (32'd2 << 12)
                   | ((im & 32'h1f) << 7) | 32'd35;
         2: return (f7 << 30) | regs | 32'd51;
         3: if (f3 == 1 || f3 == 5)
               return (f7 << 30) | ((im & 32'h1f) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | 32'd19;
            else
               return ((im & 32'hfff) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | 32'd19;
         4: return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3f) << 25) | (r2 << 20) | (r1 << 15)
                   | (f3 << 12) | (((im >> 1) & 32'hf) << 8) | (((im >> 11) & 1) << 7) | 32'd99;
         5: return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3ff) << 21) | (((im >> 11) & 1) << 20)
                   | (((im >> 12) & 32'hff) << 12) | (d << 7) | 32'd111;
         6: return (im & 32'hfffff000) | (d << 7) | 32'd55;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit m_reject(input int k, input logic [31:0] im);
      int s;
      bit bad;
      s = $signed(im);
      case (k)
         0, 1, 3: bad = (s < -2048) || (s > 2047);
         4:       bad = im[0] || (s < -4096) || (s > 4095);
         5:       bad = im[0] || (s < -1048576) || (s > 1048575);
         6:       bad = (im & 32'hfff) != 0;
         default: bad = 1'b0;
      endcase
      return (k == 7) || (c_check && bad);
   endfunction

   // One clock: drive at posedge+1, check ready, then check outputs at next posedge+1.
   task automatic cyc(input bit s, input bit v, input bit last, input logic [2:0] k,
                      input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [2:0] f3, input bit f7, input logic [31:0] im);
      bit rdy, acc, rej;
      logic [31:0] enc;
      int addr;
      start = s; in_valid = v; in_last = last; in_kind = k; in_rd = d; in_rs1 = r1;
      in_rs2 = r2; in_funct3 = f3; in_f7b5 = f7; in_imm = im;
      #1;
      rdy = (m_state == 1) && !s && (m_count < CAP);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      acc  = v && rdy;
      rej  = m_reject(int'(k), im);
      enc  = m_enc(int'(k), 32'(d), 32'(r1), 32'(r2), 32'(f3), 32'(f7), im);
      addr = m_count;
      @(posedge clk);
      #1;
      if (s) begin
         m_count = 0;
         m_state = 1;
      end else if (acc) begin
         if (!rej) m_count++;
         if (last || m_count == CAP) m_state = 2;
      end
      chk("imem_we", 32'(imem_we), 32'(acc && !rej));
      chk("err", 32'(err), 32'(acc && rej));
      chk("count", 32'(count), 32'(m_count));
      chk("busy", 32'(busy), 32'(m_state == 1));
      chk("done", 32'(done), 32'(m_state == 2));
      if (acc && !rej) begin
         chk("imem_addr", 32'(imem_addr), 32'(addr));
         chk("imem_wdata", imem_wdata, enc);
      end
   endtask

   task automatic idle();
      cyc(0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 0, 32'd0);
   endtask

   task automatic go();
      cyc(1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 0, 32'd0);
   endtask

   initial begin
      logic [31:0] im;
      logic [2:0]  k;
      reset = 1'b1; start = 0; in_valid = 0; in_last = 0; in_kind = 0; in_rd = 0;
      in_rs1 = 0; in_rs2 = 0; in_funct3 = 0; in_f7b5 = 0; in_imm = 0;
      @(posedge clk);
      #1;
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      idle();

      // addi x1,x0,5
      go();
      cyc(0, 1, 0, 3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 0, 32'd5);
      chk("addi_wdata", imem_wdata, 32'h00500093);
      chk("addi_count", 32'(count), 32'd1);
      // sw x2,8(x1) then beq x1,x2,-4 back-to-back
      cyc(0, 1, 0, 3'd1, 5'd0, 5'd1, 5'd2, 3'd2, 0, 32'd8);
      chk("sw_wdata", imem_wdata, 32'h0020A423);
      chk("sw_addr", 32'(imem_addr), 32'd1);
      cyc(0, 1, 0, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 0, 32'hFFFFFFFC);
      chk("beq_we", 32'(imem_we), 32'd1);
      chk("beq_wdata", imem_wdata, 32'hFE208EE3);
      chk("beq_addr", 32'(imem_addr), 32'd2);
      // jal x1,8 then lui x5 with last
      cyc(0, 1, 0, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 0, 32'd8);
      chk("jal_wdata", imem_wdata, 32'h008000EF);
      cyc(0, 1, 1, 3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 0, 32'h12345000);
      chk("lui_wdata", imem_wdata, 32'h123452B7);
      chk("lui_done", 32'(done), 32'd1);
      chk("lui_ready", 32'(in_ready), 32'd0);
      idle();

      // illegal kind: err pulse, no write
      go();
      cyc(0, 1, 0, 3'd7, 5'd3, 5'd3, 5'd3, 3'd0, 0, 32'd0);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_we", 32'(imem_we), 32'd0);
      chk("ill_count", 32'(count), 32'd0);
      idle();
      chk("ill_err_pulse", 32'(err), 32'd0);

      // out-of-range addi
      cyc(0, 1, 0, 3'd3, 5'd1, 5'd0, 5'd0, 3'd0, 0, 32'd2048);
`ifdef ENC_RANGE_CHECK_EN
      chk("imm2048_err", 32'(err), 32'd1);
      chk("imm2048_we", 32'(imem_we), 32'd0);
`else
      chk("imm2048_wdata", imem_wdata, 32'h80000093);
      chk("imm2048_we", 32'(imem_we), 32'd1);
`endif

      // pending write while start is asserted, then reset mid-stream
      cyc(0, 1, 0, 3'd2, 5'd4, 5'd5, 5'd6, 3'd0, 1, 32'd0);
      go();
      cyc(0, 1, 0, 3'd3, 5'd7, 5'd1, 5'd0, 3'd5, 1, 32'd3);
      reset = 1'b1;
      #1;
      chk("mid_rst_we", 32'(imem_we), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      m_count = 0;
      m_state = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;

      // fill to capacity: extra bundles must be refused
      go();
      for (int i = 0; i < CAP + 3; i++)
         cyc(0, 1, 0, 3'd3, 5'(i), 5'd2, 5'd0, 3'd0, 0, 32'(i));
      chk("full_count", 32'(count), 32'(CAP));
      chk("full_done", 32'(done), 32'd1);
      chk("full_ready", 32'(in_ready), 32'd0);

      // randomized traffic
      go();
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       im = 32'($urandom_range(0, 4095)) - 32'd2048;
            1:       im = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFFFFFE;
            2:       im = $urandom;
            default: im = $urandom & 32'hFFFFF000;
         endcase
         k = 3'($urandom_range(0, 7));
         cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
             k, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), im);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
